rwave_stream_detect: RTL and testbench

// Parametrised streaming R-peak detector for the level-3 approximation (cA) path.
// It accepts one cA sample per valid beat instead of a fixed bank of parallel cA ports.

---
 rtl/rwave_stream_detect.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_rwave_stream_detect.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwave_stream_detect.sv
// ---------------------------------------------------------------------------
// rwave_stream_detect
//
// Streaming R-peak detector for the level-3 approximation (cA) path of the
// wavelet front end. Samples arrive one per accepted beat. The block waits
// for a programmable QRS window [win_start, win_end] and tracks the extremum
// inside it. When the window closes, it compares the best magnitude against
// a signed threshold. It then reports the peak through a one-cycle Rp pulse,
// or flags a one-cycle miss pulse. After each window a refractory count of
// accepted samples runs, and a one-deep pending register holds the next
// window so that back-to-back beats are not lost.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   enable_i     global qualifier; when low every register holds
//   s_valid_i    sample strobe (accepted when s_valid_i & enable_i)
//   s_data_i     signed cA sample
//   win_load_i   latch win_start_i/win_end_i/thr_i/mode_neg_i as next window
//   win_start_i  first sample index of the search window
//   win_end_i    last sample index of the search window (inclusive)
//   thr_i        signed detection threshold, compared against magnitude
//   mode_neg_i   1 = search most-negative excursion, 0 = most-positive
//   r_peak_o     raw signed sample at the last detected peak
//   r_pos_o      sample index of the last detected peak
//   rp_o         one-cycle pulse, peak accepted, r_peak_o/r_pos_o updated
//   miss_o       one-cycle pulse, window closed below threshold
//   busy_o       high while a window is armed, searched, closed or refracting
// ---------------------------------------------------------------------------
module rwave_stream_detect #(
    parameter int DW          = 17,
    parameter int PW          = 12,
    parameter int REFRACT_LEN = 40
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 s_valid_i,
    input  logic signed [DW-1:0] s_data_i,
    input  logic                 win_load_i,
    input  logic        [PW-1:0] win_start_i,
    input  logic        [PW-1:0] win_end_i,
    input  logic signed [DW-1:0] thr_i,
    input  logic                 mode_neg_i,
    output logic signed [DW-1:0] r_peak_o,
    output logic        [PW-1:0] r_pos_o,
    output logic                 rp_o,
    output logic                 miss_o,
    output logic                 busy_o
);

    localparam int CW = (REFRACT_LEN > 0) ? $clog2(REFRACT_LEN + 1) : 1;

    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SEARCH,
        ST_CLOSE,
        ST_REFRACT
    } state_e;

    state_e state_q, state_d;

    logic        [PW-1:0] idx_q, idx_d;

    // Active window parameters, latched when the window is armed.
    logic        [PW-1:0] win_start_q, win_start_d;
    logic        [PW-1:0] win_end_q, win_end_d;
    logic signed [DW-1:0] win_thr_q, win_thr_d;
    logic                 win_neg_q, win_neg_d;

    // One-deep pending window written while the detector is busy.
    logic                 pend_valid_q, pend_valid_d;
    logic        [PW-1:0] pend_start_q, pend_start_d;
    logic        [PW-1:0] pend_end_q, pend_end_d;
    logic signed [DW-1:0] pend_thr_q, pend_thr_d;
    logic                 pend_neg_q, pend_neg_d;

    // Running best candidate inside the current window.
    logic signed [DW-1:0] best_mag_q, best_mag_d;
    logic signed [DW-1:0] best_raw_q, best_raw_d;
    logic        [PW-1:0] best_pos_q, best_pos_d;

    logic        [CW-1:0] refract_cnt_q, refract_cnt_d;

    logic signed [DW-1:0] r_peak_q, r_peak_d;
    logic        [PW-1:0] r_pos_q, r_pos_d;
    logic                 rp_q, rp_d;
    logic                 miss_q, miss_d;

    logic                 accept;
    logic signed [DW-1:0] mag;

    assign accept = enable_i & s_valid_i;

    // Inverted-QRS mode negates the sample. The most negative code has no
    // positive counterpart, so it saturates to the largest positive value.
    always_comb begin
        mag = s_data_i;
        if (win_neg_q) begin
            if (s_data_i == SMIN) begin
                mag = SMAX;
            end else begin
                mag = -s_data_i;
            end
        end
    end

    // Next-state logic. The pulse outputs default to zero on every cycle,
    // so a close step that waits on a low enable_i only delays its pulse.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        win_start_d   = win_start_q;
        win_end_d     = win_end_q;
        win_thr_d     = win_thr_q;
        win_neg_d     = win_neg_q;
        pend_valid_d  = pend_valid_q;
        pend_start_d  = pend_start_q;
        pend_end_d    = pend_end_q;
        pend_thr_d    = pend_thr_q;
        pend_neg_d    = pend_neg_q;
        best_mag_d    = best_mag_q;
        best_raw_d    = best_raw_q;
        best_pos_d    = best_pos_q;
        refract_cnt_d = refract_cnt_q;
        r_peak_d      = r_peak_q;
        r_pos_d       = r_pos_q;
        rp_d          = 1'b0;
        miss_d        = 1'b0;

        if (enable_i) begin
            if (accept) begin
                idx_d = idx_q + 1'b1;
            end

            // While busy, a load goes to the pending slot. A later load
            // overwrites an earlier one.
            if (win_load_i && (state_q != ST_IDLE)) begin
                pend_valid_d = 1'b1;
                pend_start_d = win_start_i;
                pend_end_d   = win_end_i;
                pend_thr_d   = thr_i;
                pend_neg_d   = mode_neg_i;
            end

            case (state_q)
                ST_IDLE: begin
                    if (win_load_i) begin
                        win_start_d  = win_start_i;
                        win_end_d    = win_end_i;
                        win_thr_d    = thr_i;
                        win_neg_d    = mode_neg_i;
                        pend_valid_d = 1'b0;
                        state_d      = ST_ARM;
                    end else if (pend_valid_q) begin
                        win_start_d  = pend_start_q;
                        win_end_d    = pend_end_q;
                        win_thr_d    = pend_thr_q;
                        win_neg_d    = pend_neg_q;
                        pend_valid_d = 1'b0;
                        state_d      = ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (accept && (idx_q == win_start_q)) begin
                        best_mag_d = mag;
                        best_raw_d = s_data_i;
                        best_pos_d = idx_q;
                        if (win_start_q == win_end_q) begin
                            state_d = ST_CLOSE;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end

                // A strict compare keeps the earliest sample on a tie.
                ST_SEARCH: begin
                    if (accept) begin
                        if (mag > best_mag_q) begin
                            best_mag_d = mag;
                            best_raw_d = s_data_i;
                            best_pos_d = idx_q;
                        end
                        if (idx_q == win_end_q) begin
                            state_d = ST_CLOSE;
                        end
                    end
                end

                ST_CLOSE: begin
                    if (best_mag_q >= win_thr_q) begin
                        rp_d     = 1'b1;
                        r_peak_d = best_raw_q;
                        r_pos_d  = best_pos_q;
                    end else begin
                        miss_d = 1'b1;
                    end
                    if (REFRACT_LEN == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        refract_cnt_d = CW'(REFRACT_LEN);
                        state_d       = ST_REFRACT;
                    end
                end

                ST_REFRACT: begin
                    if (accept) begin
                        if (refract_cnt_q <= CW'(1)) begin
                            refract_cnt_d = '0;
                            state_d       = ST_IDLE;
                        end else begin
                            refract_cnt_d = refract_cnt_q - 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register. A reset in the middle of a window discards the window
    // without producing a pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            win_start_q   <= '0;
            win_end_q     <= '0;
            win_thr_q     <= '0;
            win_neg_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_start_q  <= '0;
            pend_end_q    <= '0;
            pend_thr_q    <= '0;
            pend_neg_q    <= 1'b0;
            best_mag_q    <= '0;
            best_raw_q    <= '0;
            best_pos_q    <= '0;
            refract_cnt_q <= '0;
            r_peak_q      <= '0;
            r_pos_q       <= '0;
            rp_q          <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            win_start_q   <= win_start_d;
            win_end_q     <= win_end_d;
            win_thr_q     <= win_thr_d;
            win_neg_q     <= win_neg_d;
            pend_valid_q  <= pend_valid_d;
            pend_start_q  <= pend_start_d;
            pend_end_q    <= pend_end_d;
            pend_thr_q    <= pend_thr_d;
            pend_neg_q    <= pend_neg_d;
            best_mag_q    <= best_mag_d;
            best_raw_q    <= best_raw_d;
            best_pos_q    <= best_pos_d;
            refract_cnt_q <= refract_cnt_d;
            r_peak_q      <= r_peak_d;
            r_pos_q       <= r_pos_d;
            rp_q          <= rp_d;
            miss_q        <= miss_d;
        end
    end

    assign r_peak_o = r_peak_q;
    assign r_pos_o  = r_pos_q;
    assign rp_o     = rp_q;
    assign miss_o   = miss_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rwave_stream_detect.sv
// ---------------------------------------------------------------------------
// tb_rwave_stream_detect
//
// Drives cA sample streams with randomised filler values and random
// enable/valid gaps into rwave_stream_detect. Outputs are compared every
// cycle against a transaction-level reference model that records each
// window's samples in queues and picks the peak by a plain argmax when the
// window closes.
// ---------------------------------------------------------------------------
module tb_rwave_stream_detect;

    localparam int DW   = 17;
    localparam int PW   = 12;
    localparam int RL   = 40;
    localparam int NIDX = 1 << PW;
    localparam int MAXP = (1 << (DW - 1)) - 1;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 enable_i;
    logic                 s_valid_i;
    logic signed [DW-1:0] s_data_i;
    logic                 win_load_i;
    logic        [PW-1:0] win_start_i;
    logic        [PW-1:0] win_end_i;
    logic signed [DW-1:0] thr_i;
    logic                 mode_neg_i;
    logic signed [DW-1:0] r_peak_o;
    logic        [PW-1:0] r_pos_o;
    logic                 rp_o;
    logic                 miss_o;
    logic                 busy_o;

    int nVectors = 0;
    int nMiss    = 0;

    // Reference model state
    int  mIdx;
    bit  mWaitStart;
    bit  mCollect;
    bit  mCloseDue;
    int  mRefractLeft;
    int  wStart, wEnd, wThr;
    bit  wNeg;
    bit  pValid;
    int  pStart, pEnd, pThr;
    bit  pNeg;
    int  qMag[$];
    int  qRaw[$];
    int  qPos[$];
    int  expPeak, expPos;
    bit  expRp, expMiss;

    always #5 clk_i = ~clk_i;

    rwave_stream_detect #(
        .DW(DW),
        .PW(PW),
        .REFRACT_LEN(RL)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .win_load_i (win_load_i),
        .win_start_i(win_start_i),
        .win_end_i  (win_end_i),
        .thr_i      (thr_i),
        .mode_neg_i (mode_neg_i),
        .r_peak_o   (r_peak_o),
        .r_pos_o    (r_pos_o),
        .rp_o       (rp_o),
        .miss_o     (miss_o),
        .busy_o     (busy_o)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        nVectors++;
        if (obs != exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int magOf(input int d, input bit neg);
        int m;
        m = neg ? -d : d;
        if (m > MAXP) m = MAXP;
        return m;
    endfunction

    task automatic modelReset();
        mIdx = 0;
        mWaitStart = 0;
        mCollect = 0;
        mCloseDue = 0;
        mRefractLeft = 0;
        wStart = 0; wEnd = 0; wThr = 0; wNeg = 0;
        pValid = 0; pStart = 0; pEnd = 0; pThr = 0; pNeg = 0;
        qMag.delete(); qRaw.delete(); qPos.delete();
        expPeak = 0; expPos = 0; expRp = 0; expMiss = 0;
    endtask

    // One clock edge of the reference behaviour, decided from the state
    // that was current before the edge.
    task automatic modelStep(input bit en, input bit v, input int d, input bit ld,
                             input int ws, input int we, input int th, input bit ng);
        bit idle;
        int b;
        expRp = 0;
        expMiss = 0;
        if (!en) return;
        idle = !mWaitStart && !mCollect && !mCloseDue && (mRefractLeft == 0);
        if (mCloseDue) begin
            b = 0;
            for (int i = 1; i < qMag.size(); i++) begin
                if (qMag[i] > qMag[b]) b = i;
            end
            if (qMag[b] >= wThr) begin
                expRp = 1;
                expPeak = qRaw[b];
                expPos = qPos[b];
            end else begin
                expMiss = 1;
            end
            qMag.delete(); qRaw.delete(); qPos.delete();
            mCloseDue = 0;
            mRefractLeft = RL;
            if (ld) begin
                pValid = 1; pStart = ws; pEnd = we; pThr = th; pNeg = ng;
            end
        end else if (idle) begin
            if (ld) begin
                wStart = ws; wEnd = we; wThr = th; wNeg = ng;
                pValid = 0;
                mWaitStart = 1;
            end else if (pValid) begin
                wStart = pStart; wEnd = pEnd; wThr = pThr; wNeg = pNeg;
                pValid = 0;
                mWaitStart = 1;
            end
        end else begin
            if (ld) begin
                pValid = 1; pStart = ws; pEnd = we; pThr = th; pNeg = ng;
            end
            if (v) begin
                if (mWaitStart) begin
                    if (mIdx == wStart) begin
                        mWaitStart = 0;
                        qMag.push_back(magOf(d, wNeg)); qRaw.push_back(d); qPos.push_back(mIdx);
                        if (wStart == wEnd) mCloseDue = 1;
                        else mCollect = 1;
                    end
                end else if (mCollect) begin
                    qMag.push_back(magOf(d, wNeg)); qRaw.push_back(d); qPos.push_back(mIdx);
                    if (mIdx == wEnd) begin
                        mCollect = 0;
                        mCloseDue = 1;
                    end
                end else if (mRefractLeft > 0) begin
                    mRefractLeft--;
                end
            end
        end
        if (v) mIdx = (mIdx + 1) % NIDX;
    endtask

    // Drive one cycle, step the model at the clock edge and compare all
    // outputs shortly after the edge.
    task automatic applyStimulus(input bit en, input bit v, input int d, input bit ld,
                                 input int ws, input int we, input int th, input bit ng);
        int dv;
        bit busyExp;
        dv = d;
        enable_i    = en;
        s_valid_i   = v;
        s_data_i    = dv[DW-1:0];
        win_load_i  = ld;
        win_start_i = ws[PW-1:0];
        win_end_i   = we[PW-1:0];
        thr_i       = th[DW-1:0];
        mode_neg_i  = ng;
        @(posedge clk_i);
        if (rst_i) modelReset();
        else modelStep(en, v, d, ld, ws, we, th, ng);
        #1;
        busyExp = mWaitStart || mCollect || mCloseDue || (mRefractLeft > 0);
        checkOutput("rp", int'(rp_o), int'(expRp));
        checkOutput("miss", int'(miss_o), int'(expMiss));
        checkOutput("busy", int'(busy_o), int'(busyExp));
        checkOutput("r_peak", int'(r_peak_o), expPeak);
        checkOutput("r_pos", int'(r_pos_o), expPos);
    endtask

    task automatic loadWindow(input int ws, input int we, input int th, input bit ng);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, ws, we, th, ng);
    endtask

    // Feed n accepted samples. Indices p1/p2 carry pVal; every other sample
    // is base plus a random offset in [0, jit]. With gaps set, enable and
    // valid drop at random.
    task automatic streamN(input int n, input int p1, input int p2, input int pVal,
                           input int base, input int jit, input bit gaps);
        int acc;
        bit en, v;
        int d;
        acc = 0;
        for (int cyc = 0; cyc < 20 * n + 100 && acc < n; cyc++) begin
            en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            v  = gaps ? ($urandom_range(0, 4) != 0) : 1'b1;
            d  = ((mIdx == p1) || (mIdx == p2)) ? pVal : base + int'($urandom_range(0, jit));
            applyStimulus(en, v, d, 1'b0, 0, 0, 0, 1'b0);
            if (en && v) acc++;
        end
        if (acc < n) begin
            nVectors++;
            nMiss++;
            $display("[TB] FAIL stream_budget: got %0d samples, expected %0d", acc, n);
        end
    endtask

    task automatic asyncReset();
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("rst_async_rp", int'(rp_o), 0);
        checkOutput("rst_async_miss", int'(miss_o), 0);
        checkOutput("rst_async_busy", int'(busy_o), 0);
        checkOutput("rst_async_peak", int'(r_peak_o), 0);
        checkOutput("rst_async_pos", int'(r_pos_o), 0);
        modelReset();
        applyStimulus(1'b1, 1'b1, 700, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 700, 1'b0, 0, 0, 0, 1'b0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        modelReset();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0);
        rst_i = 1'b0;

        $display("[TB] positive peak, window 10..20");
        loadWindow(10, 20, 100, 1'b0);
        streamN(80, 15, -1, 500, 50, 0, 1'b0);
        checkOutput("pos_peak", int'(r_peak_o), 500);
        checkOutput("pos_pos", int'(r_pos_o), 15);

        $display("[TB] reset in the middle of a search");
        loadWindow(100, 130, 50, 1'b0);
        streamN(35, 105, -1, 700, 20, 10, 1'b0);
        asyncReset();
        streamN(40, -1, -1, 0, 700, 0, 1'b0);

        $display("[TB] inverted QRS with tie");
        loadWindow(50, 60, 200, 1'b1);
        streamN(80, 52, 54, -300, 50, 0, 1'b0);
        checkOutput("neg_peak", int'(r_peak_o), -300);
        checkOutput("neg_pos", int'(r_pos_o), 52);

        $display("[TB] miss, then saturation");
        loadWindow(130, 140, 100, 1'b0);
        streamN(70, -1, -1, 0, 80, 0, 1'b0);
        checkOutput("miss_hold_peak", int'(r_peak_o), -300);
        loadWindow(200, 210, 100, 1'b1);
        streamN(70, 205, -1, -65536, 10, 20, 1'b0);
        checkOutput("sat_peak", int'(r_peak_o), -65536);
        checkOutput("sat_pos", int'(r_pos_o), 205);

        $display("[TB] wrapping window 4090..5");
        loadWindow(4090, 5, 300, 1'b0);
        streamN(NIDX - 260 + 60, 2, -1, 900, 0, 200, 1'b0);
        checkOutput("wrap_peak", int'(r_peak_o), 900);
        checkOutput("wrap_pos", int'(r_pos_o), 2);

        $display("[TB] pending window, refractory and enable gaps");
        asyncReset();
        loadWindow(5, 15, 100, 1'b0);
        streamN(10, 10, 32, 400, 0, 150, 1'b1);
        loadWindow(500, 600, 50, 1'b1);
        loadWindow(30, 35, 200, 1'b0);
        streamN(NIDX + 60 - 10, 10, 32, 1000, 0, 150, 1'b1);
        checkOutput("pend_peak", int'(r_peak_o), 1000);
        checkOutput("pend_pos", int'(r_pos_o), 32);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
